// File: rtl/shift_ctrl.sv
// Serial shift sequencer: parallel word in, LSB-first serial out/in at a programmable bit rate.
// Define PARITY_EN to append an even-parity bit to each frame and check it on receive.
module shift_ctrl #(
    parameter int W   = 8,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic         sdo,
    input  logic         sdi,
    output logic         shift_en,
    output logic         busy,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    output logic         rx_perr
);

`ifdef PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int BCW = $clog2(NB + 1);
    localparam int DCW = $clog2(DIV + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(NB - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [BCW-1:0] bit_cnt;
    logic [DCW-1:0] div_cnt;
    logic [NB-1:0]  tx_sh;
    logic [NB-1:0]  rx_sh;
    logic [NB-1:0]  tx_word;
    logic           accept;
    logic           tick;
    logic           last_tick;

    // The parity bit rides in the top of the shift word so it goes out after the data bits.
`ifdef PARITY_EN
    assign tx_word = {^tx_data, tx_data};
`else
    assign tx_word = tx_data;
`endif

    assign accept    = (state == IDLE) && tx_valid && tx_ready;
    assign tick      = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign last_tick = tick && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sdo       = 1'b1;
        shift_en  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sdo      = tx_sh[0];
                shift_en = tick;
                busy     = 1'b1;
                if (last_tick) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // rx_valid is registered so it coincides with the cycle rx_data first shows the new word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ready <= 1'b0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    tx_ready <= ~accept;
                    if (accept) begin
                        tx_sh   <= tx_word;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        tx_sh   <= tx_sh >> 1;
                        rx_sh   <= {sdi, rx_sh[NB-1:1]};
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    rx_data  <= rx_sh[W-1:0];
                    rx_valid <= 1'b1;
                    tx_ready <= 1'b1;
                    bit_cnt  <= '0;
                end
                default: begin
                    tx_ready <= 1'b0;
                end
            endcase
        end
    end

    // Even parity: XOR over received data plus parity bit is zero for a clean frame.
`ifdef PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_perr <= 1'b0;
        end else if (state == DONE) begin
            rx_perr <= ^rx_sh;
        end
    end
`else
    assign rx_perr = 1'b0;
`endif

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: per-cycle timing model plus scoreboard of accepted words.
// A DIV=4 instance carries most scenarios; a DIV=1 instance covers one-bit-per-clock operation.
`timescale 1ns/1ps
module tb_shift_ctrl;
    localparam int W   = 8;
    localparam int DIV = 4;
`ifdef PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int FL = NB * DIV;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         sdo;
    logic         sdi;
    logic         shift_en;
    logic         busy;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_perr;
    logic         sdi_ovr;
    logic         sdi_val;

    logic [W-1:0] tx_data1;
    logic         tx_valid1;
    logic         tx_ready1;
    logic         sdo1;
    logic         sdi1;
    logic         shift_en1;
    logic         busy1;
    logic [W-1:0] rx_data1;
    logic         rx_valid1;
    logic         rx_perr1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [W-1:0] sb[$];
    int           acc_cyc[$];

    always #5 clk = ~clk;

    assign sdi  = sdi_ovr ? sdi_val : sdo;
    assign sdi1 = sdo1;

    shift_ctrl #(.W(W), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .sdo(sdo), .sdi(sdi), .shift_en(shift_en), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_perr(rx_perr)
    );

    shift_ctrl #(.W(W), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .sdo(sdo1), .sdi(sdi1), .shift_en(shift_en1), .busy(busy1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_perr(rx_perr1)
    );

    // Record every handshake on the DIV=4 instance as it happens.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst && tx_valid && tx_ready) begin
            sb.push_back(tx_data);
            acc_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // One frame on the DIV=4 instance; force_bit>=0 overrides sdi for that bit slot.
    task automatic run_frame(input logic [W-1:0] word, input int force_bit, input logic force_val);
        logic [NB-1:0] sent;
        logic [NB-1:0] recv;
        logic [W-1:0]  w;
        logic          exp_perr;
        int            n;
        int            pulses;
        n      = 0;
        pulses = 0;
        @(negedge clk);
        tx_data  = word;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tx_ready) begin
            errors++;
            $display("[TB] FAIL accept_wait tx_ready=%b expected 1", tx_ready);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        w = word;
        checks++;
        if (sb.size() != 1) begin
            errors++;
            $display("[TB] FAIL sb_accept count=%0d expected 1", sb.size());
        end
        if (sb.size() > 0) w = sb.pop_front();
        sb.delete();
        sent[W-1:0] = w;
`ifdef PARITY_EN
        sent[NB-1] = ^w;
`endif
        recv = sent;
        if (force_bit >= 0) recv[force_bit] = force_val;
`ifdef PARITY_EN
        exp_perr = ^recv;
`else
        exp_perr = 1'b0;
`endif
        for (int k = 0; k <= FL + 1; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (sdo !== ((k < FL) ? sent[k / DIV] : 1'b1)) begin
                errors++;
                $display("[TB] FAIL sdo k=%0d got=%b expected=%b", k, sdo, (k < FL) ? sent[k / DIV] : 1'b1);
            end
            checks++;
            if (shift_en !== ((k < FL) && (k % DIV == DIV - 1))) begin
                errors++;
                $display("[TB] FAIL shift_en k=%0d got=%b", k, shift_en);
            end
            checks++;
            if (busy !== (k <= FL)) begin
                errors++;
                $display("[TB] FAIL busy k=%0d got=%b", k, busy);
            end
            checks++;
            if (tx_ready !== (k == FL + 1)) begin
                errors++;
                $display("[TB] FAIL tx_ready k=%0d got=%b", k, tx_ready);
            end
            checks++;
            if (rx_valid !== (k == FL + 1)) begin
                errors++;
                $display("[TB] FAIL rx_valid k=%0d got=%b", k, rx_valid);
            end
            if (shift_en) pulses++;
            sdi_ovr = (force_bit >= 0) && (k < FL) && (k / DIV == force_bit);
            sdi_val = force_val;
            if (k < FL - 1) begin
                tx_valid = 1'($urandom);
                tx_data  = W'($urandom);
            end else begin
                tx_valid = 1'b0;
            end
        end
        sdi_ovr = 1'b0;
        checks++;
        if (rx_data !== recv[W-1:0]) begin
            errors++;
            $display("[TB] FAIL rx_data got=%h expected=%h", rx_data, recv[W-1:0]);
        end
        checks++;
        if (rx_perr !== exp_perr) begin
            errors++;
            $display("[TB] FAIL rx_perr got=%b expected=%b", rx_perr, exp_perr);
        end
        checks++;
        if (pulses != NB) begin
            errors++;
            $display("[TB] FAIL shift_en_count got=%0d expected=%0d", pulses, NB);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; tx_valid = 1'b0; tx_data = '0; sdi_ovr = 1'b0; sdi_val = 1'b0;
        tx_valid1 = 1'b0; tx_data1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_ready, sdo, shift_en, busy, rx_valid, rx_perr} !== 6'b010000 || rx_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values ready/sdo/sh/busy/rv/pe=%b rx_data=%h", {tx_ready, sdo, shift_en, busy, rx_valid, rx_perr}, rx_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_before_edge got=%b expected 0", tx_ready);
        end
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_release got=%b expected 1", tx_ready);
        end
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || sdo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe busy=%b sdo=%b expected 1 0", busy, sdo);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({tx_ready, sdo, shift_en, busy, rx_valid, rx_perr} !== 6'b010000 || rx_data !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset ready/sdo/sh/busy/rv/pe=%b rx_data=%h", {tx_ready, sdo, shift_en, busy, rx_valid, rx_perr}, rx_data);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_abort got=%b expected 1", tx_ready);
        end
    endtask

    task automatic test_div1();
        logic [NB-1:0] sent;
        int            pulses;
        int            n;
        pulses = 0;
        n      = 0;
        sent[W-1:0] = 8'hA5;
`ifdef PARITY_EN
        sent[NB-1] = ^sent[W-1:0];
`endif
        @(negedge clk);
        tx_data1  = 8'hA5;
        tx_valid1 = 1'b1;
        while (!tx_ready1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        for (int k = 0; k <= NB + 1; k++) begin
            @(negedge clk);
            tx_valid1 = 1'b0;
            checks++;
            if (sdo1 !== ((k < NB) ? sent[k] : 1'b1)) begin
                errors++;
                $display("[TB] FAIL div1_sdo k=%0d got=%b", k, sdo1);
            end
            checks++;
            if (rx_valid1 !== (k == NB + 1)) begin
                errors++;
                $display("[TB] FAIL div1_rx_valid k=%0d got=%b", k, rx_valid1);
            end
            if (shift_en1) pulses++;
        end
        checks++;
        if (pulses != NB) begin
            errors++;
            $display("[TB] FAIL div1_pulses got=%0d expected=%0d", pulses, NB);
        end
        checks++;
        if (rx_data1 !== 8'hA5 || rx_perr1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div1_rx rx_data=%h perr=%b expected a5 0", rx_data1, rx_perr1);
        end
    endtask

    task automatic test_div4_single();
        run_frame(8'h01, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_w[2];
        int           got;
        int           n;
        got = 0;
        n   = 0;
        exp_w[0] = 8'h3C;
        exp_w[1] = 8'hC3;
        sb.delete();
        acc_cyc.delete();
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        while (got < 2 && n < 3 * (FL + 2) + 20) begin
            @(negedge clk);
            n++;
            if (acc_cyc.size() == 1) tx_data = 8'hC3;
            if (acc_cyc.size() >= 2) tx_valid = 1'b0;
            if (rx_valid) begin
                checks++;
                if (rx_data !== exp_w[got] || rx_perr !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_rx idx=%0d got=%h perr=%b expected=%h", got, rx_data, rx_perr, exp_w[got]);
                end
                got++;
            end
        end
        tx_valid = 1'b0;
        checks++;
        if (got != 2) begin
            errors++;
            $display("[TB] FAIL b2b_frames got=%0d expected 2", got);
        end
        checks++;
        if (acc_cyc.size() < 2) begin
            errors++;
            $display("[TB] FAIL b2b_accepts got=%0d expected 2", acc_cyc.size());
        end else if (acc_cyc[1] - acc_cyc[0] != FL + 2) begin
            errors++;
            $display("[TB] FAIL b2b_spacing got=%0d expected=%0d", acc_cyc[1] - acc_cyc[0], FL + 2);
        end
        sb.delete();
    endtask

    task automatic test_abort();
        int n;
        int ticks;
        int seen;
        n = 0; ticks = 0; seen = 0;
        sb.delete();
        @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        n = 0;
        while (ticks < 3 && n < 10 * DIV) begin
            @(negedge clk);
            tx_valid = 1'b0;
            n++;
            if (shift_en) ticks++;
        end
        checks++;
        if (ticks != 3) begin
            errors++;
            $display("[TB] FAIL abort_ticks got=%0d expected 3", ticks);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({tx_ready, sdo, busy, rx_valid} !== 4'b0100 || rx_data !== '0) begin
            errors++;
            $display("[TB] FAIL abort_reset ready/sdo/busy/rv=%b rx_data=%h", {tx_ready, sdo, busy, rx_valid}, rx_data);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < FL + 4; k++) begin
            @(negedge clk);
            if (rx_valid) seen++;
        end
        checks++;
        if (seen != 0 || rx_data !== '0) begin
            errors++;
            $display("[TB] FAIL abort_no_rx pulses=%0d rx_data=%h expected 0 00", seen, rx_data);
        end
        run_frame(8'h12, -1, 1'b0);
    endtask

    task automatic test_parity();
        run_frame(8'h07, -1, 1'b0);
`ifdef PARITY_EN
        run_frame(8'h07, W, 1'b0);
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_frame(W'($urandom), int'($urandom_range(0, NB - 1)), 1'($urandom));
            end else begin
                run_frame(W'($urandom), -1, 1'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div1();
        test_div4_single();
        test_back_to_back();
        test_abort();
        test_parity();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
